// File: rtl/queue_pkg.sv
// Shared widths and types for the 8x72 queue and its storage macro.
package queue_pkg;

    localparam int unsigned QUEUE_W     = 72;
    localparam int unsigned QUEUE_DEPTH = 8;
    localparam int unsigned QUEUE_PTR_W = 3;

    typedef logic [QUEUE_PTR_W-1:0] queue_ptr_t;
    typedef logic [QUEUE_W-1:0]     queue_data_t;

endpackage

// File: rtl/ram_8x72.sv
// Two-port 8x72 storage macro: synchronous write port, asynchronous read port.
module ram_8x72
    import queue_pkg::*;
(
    input  logic        i_wr_clk,
    input  logic        i_wr_en,
    input  queue_ptr_t  i_wr_addr,
    input  queue_data_t i_wr_data,
    input  logic        i_rd_clk,
    input  logic        i_rd_en,
    input  queue_ptr_t  i_rd_addr,
    output queue_data_t o_rd_data
);

    queue_data_t r_mem [QUEUE_DEPTH];

    // Read port is flow-through in this model, so its clock has no load.
    logic w_unused_rd_clk;
    assign w_unused_rd_clk = i_rd_clk;

    always_ff @(posedge i_wr_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = i_rd_en ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/queue_8x72.sv
// Eight-entry 72-bit ready/valid FIFO; pointers and flags here, data in ram_8x72.
module queue_8x72
    import queue_pkg::*;
#(
    parameter bit FLOW = 1'b0,
    parameter bit PIPE = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enq_valid,
    output logic        enq_ready,
    input  queue_data_t enq_bits,
    output logic        deq_valid,
    input  logic        deq_ready,
    output queue_data_t deq_bits,
    output logic [3:0]  count
);

    queue_ptr_t  r_enq_ptr;
    queue_ptr_t  r_deq_ptr;
    logic        r_maybe_full;

    logic        w_ptr_match;
    logic        w_empty;
    logic        w_full;
    logic        w_do_enq;
    logic        w_do_deq;
    logic        w_bypass;
    logic        w_stored_enq;
    logic        w_stored_deq;
    queue_ptr_t  w_ptr_diff;
    queue_data_t w_rd_data;

    assign w_ptr_match = (r_enq_ptr == r_deq_ptr);
    assign w_empty     = w_ptr_match & ~r_maybe_full;
    assign w_full      = w_ptr_match & r_maybe_full;

    assign enq_ready = ~w_full | (PIPE & deq_ready);
    assign deq_valid = ~w_empty | (FLOW & enq_valid);
    assign deq_bits  = (FLOW & w_empty) ? enq_bits : w_rd_data;

    assign w_do_enq = enq_ready & enq_valid;
    assign w_do_deq = deq_ready & deq_valid;

    // An empty FLOW queue hands the word straight to the consumer; storage is untouched.
    assign w_bypass     = FLOW & w_empty & deq_ready;
    assign w_stored_enq = w_do_enq & ~w_bypass;
    assign w_stored_deq = w_do_deq & ~w_empty;

    assign w_ptr_diff = r_enq_ptr - r_deq_ptr;
    assign count      = {w_full, w_ptr_diff};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_enq_ptr    <= '0;
            r_deq_ptr    <= '0;
            r_maybe_full <= 1'b0;
        end else begin
            if (w_stored_enq) begin
                r_enq_ptr <= r_enq_ptr + 3'd1;
            end
            if (w_stored_deq) begin
                r_deq_ptr <= r_deq_ptr + 3'd1;
            end
            if (w_stored_enq != w_stored_deq) begin
                r_maybe_full <= w_stored_enq;
            end
        end
    end

    ram_8x72 u_ram (
        .i_wr_clk  (clock),
        .i_wr_en   (w_stored_enq),
        .i_wr_addr (r_enq_ptr),
        .i_wr_data (enq_bits),
        .i_rd_clk  (clock),
        .i_rd_en   (1'b1),
        .i_rd_addr (r_deq_ptr),
        .o_rd_data (w_rd_data)
    );

endmodule
